// File: rtl/mc_ctrl.sv
// Multi-cycle main controller for the MIPS-lite core: sequences PC/IR/GRF/ALU/DM
// through FETCH, DECODE, EXE, MEM and WB, decoding opcode/funct into datapath enables and selects.
// Latency: outputs are combinational from state, opcode, funct and zero; state advances every clk edge.
// Backpressure: none; the datapath always accepts. reset (sync, active-high) masks all write enables.
// Ports: clk, reset, opcode/funct (IR fields), zero (ALU A==B) in; PCWr, NPCSel, IRWr, RegWr, RegDst,
// MemToReg, ALUSrc, ALUOp, ExtOp, MemWr, state out.
// Optional: define MC_CTRL_INSTR_CNT_EN to add the instr_cnt[31:0] retired-instruction counter output.
module mc_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    output logic        PCWr,
    output logic [1:0]  NPCSel,
    output logic        IRWr,
    output logic        RegWr,
    output logic [1:0]  RegDst,
    output logic [1:0]  MemToReg,
    output logic        ALUSrc,
    output logic [1:0]  ALUOp,
    output logic        ExtOp,
    output logic        MemWr,
`ifdef MC_CTRL_INSTR_CNT_EN
    output logic [2:0]  state,
    output logic [31:0] instr_cnt
`else
    output logic [2:0]  state
`endif
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXE    = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LUI  = 6'b001111;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_JR   = 6'b001000;

    logic [2:0] state_q;
    logic [2:0] state_nxt;

    logic is_r, is_addu, is_subu, is_jr, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal;
    logic pc_wr_raw, ir_wr_raw, reg_wr_raw, mem_wr_raw;

    // sll and every other R funct fall through all of these and retire as a nop from DECODE
    assign is_r    = (opcode == OP_R);
    assign is_addu = is_r && (funct == FN_ADDU);
    assign is_subu = is_r && (funct == FN_SUBU);
    assign is_jr   = is_r && (funct == FN_JR);
    assign is_ori  = (opcode == OP_ORI);
    assign is_lui  = (opcode == OP_LUI);
    assign is_lw   = (opcode == OP_LW);
    assign is_sw   = (opcode == OP_SW);
    assign is_beq  = (opcode == OP_BEQ);
    assign is_j    = (opcode == OP_J);
    assign is_jal  = (opcode == OP_JAL);

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = S_FETCH;
        case (state_q)
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: begin
                if (is_addu || is_subu || is_ori || is_lui || is_lw || is_sw || is_beq)
                    state_nxt = S_EXE;
                else
                    state_nxt = S_FETCH;
            end
            S_EXE: begin
                if (is_lw || is_sw)
                    state_nxt = S_MEM;
                else if (is_addu || is_subu || is_ori || is_lui)
                    state_nxt = S_WB;
                else
                    state_nxt = S_FETCH;
            end
            S_MEM:    state_nxt = is_lw ? S_WB : S_FETCH;
            S_WB:     state_nxt = S_FETCH;
            default:  state_nxt = S_FETCH;
        endcase
    end

    always_comb begin
        pc_wr_raw  = 1'b0;
        NPCSel     = 2'd0;
        ir_wr_raw  = 1'b0;
        reg_wr_raw = 1'b0;
        RegDst     = 2'd0;
        MemToReg   = 2'd0;
        ALUSrc     = 1'b0;
        ALUOp      = 2'd0;
        ExtOp      = 1'b0;
        mem_wr_raw = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_wr_raw = 1'b1;
                pc_wr_raw = 1'b1;
            end
            S_DECODE: begin
                if (is_j || is_jal) begin
                    pc_wr_raw = 1'b1;
                    NPCSel    = 2'd2;
                end
                // PC already holds PC+4 here, so the link value is taken straight from PC
                if (is_jal) begin
                    reg_wr_raw = 1'b1;
                    RegDst     = 2'd2;
                    MemToReg   = 2'd2;
                end
                if (is_jr) begin
                    pc_wr_raw = 1'b1;
                    NPCSel    = 2'd3;
                end
            end
            S_EXE: begin
                if (is_subu) ALUOp = 2'd1;
                if (is_ori) begin
                    ALUSrc = 1'b1;
                    ALUOp  = 2'd2;
                end
                if (is_lui) begin
                    ALUSrc = 1'b1;
                    ALUOp  = 2'd3;
                end
                if (is_lw || is_sw) begin
                    ALUSrc = 1'b1;
                    ExtOp  = 1'b1;
                end
                if (is_beq) begin
                    ALUOp = 2'd1;
                    if (zero) begin
                        pc_wr_raw = 1'b1;
                        NPCSel    = 2'd1;
                    end
                end
            end
            S_MEM: begin
                // keep the address computation alive while DM is accessed
                if (is_lw || is_sw) begin
                    ALUSrc = 1'b1;
                    ExtOp  = 1'b1;
                end
                if (is_sw) mem_wr_raw = 1'b1;
            end
            S_WB: begin
                reg_wr_raw = 1'b1;
                if (is_addu || is_subu) RegDst   = 2'd1;
                if (is_lw)              MemToReg = 2'd1;
            end
            default: ;
        endcase
    end

    // reset must stop architectural side effects immediately, not one edge later
    assign PCWr  = pc_wr_raw  & ~reset;
    assign IRWr  = ir_wr_raw  & ~reset;
    assign RegWr = reg_wr_raw & ~reset;
    assign MemWr = mem_wr_raw & ~reset;
    assign state = state_q;

`ifdef MC_CTRL_INSTR_CNT_EN
    logic [31:0] cnt_q;

    // one count per retired instruction: every return to FETCH from another state
    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= 32'd0;
        else if ((state_nxt == S_FETCH) && (state_q != S_FETCH))
            cnt_q <= cnt_q + 32'd1;
    end

    // masked so the count reads 0 for the whole reset window, including its first cycle
    assign instr_cnt = reset ? 32'd0 : cnt_q;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: per-instruction microcode reference, queued expectations,
// independent monitor comparing every cycle on the falling edge.
// Build with MC_CTRL_INSTR_CNT_EN defined to also check the retired-instruction counter.
module tb_mc_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic        PCWr, IRWr, RegWr, ALUSrc, ExtOp, MemWr;
    logic [1:0]  NPCSel, RegDst, MemToReg, ALUOp;
    logic [2:0]  state;
`ifdef MC_CTRL_INSTR_CNT_EN
    logic [31:0] instr_cnt;
`endif

    always #5 clk = ~clk;

    mc_ctrl dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .PCWr(PCWr), .NPCSel(NPCSel), .IRWr(IRWr), .RegWr(RegWr), .RegDst(RegDst),
        .MemToReg(MemToReg), .ALUSrc(ALUSrc), .ALUOp(ALUOp), .ExtOp(ExtOp), .MemWr(MemWr),
`ifdef MC_CTRL_INSTR_CNT_EN
        .state(state), .instr_cnt(instr_cnt)
`else
        .state(state)
`endif
    );

    typedef struct packed {
        logic [2:0] st;
        logic       pcwr;
        logic [1:0] npc;
        logic       irwr;
        logic       regwr;
        logic [1:0] regdst;
        logic [1:0] m2r;
        logic       alusrc;
        logic [1:0] aluop;
        logic       extop;
        logic       memwr;
    } ctl_t;

    typedef struct packed {
        ctl_t        w;
        logic        full;   // 0: state unknown, only write enables are meaningful
        logic [31:0] cnt;
    } exp_t;

    localparam int C_ADDU = 0, C_SUBU = 1, C_NOP = 2, C_JR = 3, C_ORI = 4, C_LUI = 5;
    localparam int C_LW = 6, C_SW = 7, C_BEQ = 8, C_J = 9, C_JAL = 10;

    exp_t        sb_q[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] model_cnt = 32'd0;

    // cycles per instruction class
    function automatic int cpi(input int cls);
        case (cls)
            C_LW:                         return 5;
            C_ADDU, C_SUBU, C_ORI, C_LUI,
            C_SW:                         return 4;
            C_BEQ:                        return 3;
            default:                      return 2;
        endcase
    endfunction

    // control word expected in cycle ph (0 = fetch) of an instruction of class cls
    function automatic ctl_t model(input int cls, input int ph, input logic z);
        ctl_t c;
        c = '0;
        if (ph <= 2)        c.st = 3'(ph);
        else if (cls == C_LW) c.st = 3'(ph);
        else if (cls == C_SW) c.st = 3'd3;
        else                  c.st = 3'd4;
        if (ph == 0) begin
            c.irwr = 1'b1; c.pcwr = 1'b1;
        end else begin
            case (cls)
                C_J:   begin c.pcwr = 1'b1; c.npc = 2'd2; end
                C_JAL: begin c.pcwr = 1'b1; c.npc = 2'd2; c.regwr = 1'b1; c.regdst = 2'd2; c.m2r = 2'd2; end
                C_JR:  begin c.pcwr = 1'b1; c.npc = 2'd3; end
                C_ADDU, C_SUBU: begin
                    if (ph == 2) c.aluop = (cls == C_SUBU) ? 2'd1 : 2'd0;
                    if (ph == 3) begin c.regwr = 1'b1; c.regdst = 2'd1; end
                end
                C_ORI, C_LUI: begin
                    if (ph == 2) begin c.alusrc = 1'b1; c.aluop = (cls == C_LUI) ? 2'd3 : 2'd2; end
                    if (ph == 3) c.regwr = 1'b1;
                end
                C_LW: begin
                    if (ph == 2 || ph == 3) begin c.alusrc = 1'b1; c.extop = 1'b1; end
                    if (ph == 4) begin c.regwr = 1'b1; c.m2r = 2'd1; end
                end
                C_SW: begin
                    c.alusrc = (ph >= 2); c.extop = (ph >= 2); c.memwr = (ph == 3);
                end
                C_BEQ: begin
                    if (ph == 2) begin
                        c.aluop = 2'd1;
                        if (z) begin c.pcwr = 1'b1; c.npc = 2'd1; end
                    end
                end
                default: ;
            endcase
        end
        return c;
    endfunction

    task automatic encode(input int cls, output logic [5:0] op, output logic [5:0] fn);
        fn = 6'($urandom);
        op = 6'b000000;
        case (cls)
            C_ADDU: fn = 6'b100001;
            C_SUBU: fn = 6'b100011;
            C_JR:   fn = 6'b001000;
            C_ORI:  op = 6'b001101;
            C_LUI:  op = 6'b001111;
            C_LW:   op = 6'b100011;
            C_SW:   op = 6'b101011;
            C_BEQ:  op = 6'b000100;
            C_J:    op = 6'b000010;
            C_JAL:  op = 6'b000011;
            default: begin
                case ($urandom_range(2))
                    0: fn = 6'b000000;
                    1: while (fn == 6'b100001 || fn == 6'b100011 || fn == 6'b001000) fn = 6'($urandom);
                    default: begin
                        op = 6'($urandom);
                        while (op == 6'b000000 || op == 6'b001101 || op == 6'b001111 || op == 6'b100011 ||
                               op == 6'b101011 || op == 6'b000100 || op == 6'b000010 || op == 6'b000011)
                            op = 6'($urandom);
                    end
                endcase
            end
        endcase
    endtask

    task automatic push(input ctl_t w, input logic full, input logic [31:0] cnt);
        exp_t e;
        e.w = w; e.full = full; e.cnt = cnt;
        sb_q.push_back(e);
    endtask

    // rst_ph < 0: no reset; otherwise reset is raised during that cycle of the instruction
    task automatic run_instr(input int cls, input logic zb, input int rst_ph);
        logic [5:0] op, fn;
        ctl_t       e;
        encode(cls, op, fn);
        for (int ph = 0; ph < cpi(cls); ph++) begin
            @(posedge clk);
            #1;
            // the IR only holds this instruction after FETCH, so fetch sees junk fields
            opcode = (ph == 0) ? 6'($urandom) : op;
            funct  = (ph == 0) ? 6'($urandom) : fn;
            zero   = (cls == C_BEQ && ph == 2) ? zb : 1'($urandom);
            reset  = (ph == rst_ph);
            e = model(cls, ph, zero);
            if (reset) begin
                e.pcwr = 1'b0; e.irwr = 1'b0; e.regwr = 1'b0; e.memwr = 1'b0;
                push(e, 1'b1, 32'd0);
                model_cnt = 32'd0;
                return;
            end
            push(e, 1'b1, model_cnt);
        end
        model_cnt = model_cnt + 32'd1;
    endtask

    // monitor: pop and compare one expectation per cycle
    initial begin
        exp_t e;
        ctl_t got;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                got = {state, PCWr, NPCSel, IRWr, RegWr, RegDst, MemToReg, ALUSrc, ALUOp, ExtOp, MemWr};
                checks++;
                if (e.full) begin
                    if (got !== e.w) begin
                        failures++;
                        $display("FAIL ctl t=%0t got=%h want=%h (st=%0d/%0d)", $time, got, e.w, got.st, e.w.st);
                    end
                end else if ({got.pcwr, got.irwr, got.regwr, got.memwr} !== 4'b0000) begin
                    failures++;
                    $display("FAIL reset_we t=%0t got=%b want=0000", $time,
                             {got.pcwr, got.irwr, got.regwr, got.memwr});
                end
`ifdef MC_CTRL_INSTR_CNT_EN
                checks++;
                if (instr_cnt !== e.cnt) begin
                    failures++;
                    $display("FAIL instr_cnt t=%0t got=%0d want=%0d", $time, instr_cnt, e.cnt);
                end
`endif
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ctl_t e;
        int   cls, rph;
        reset = 1'b1; opcode = 6'd0; funct = 6'd0; zero = 1'b0;
        // two reset cycles: state unknown in the first, FETCH with enables masked in the second
        @(posedge clk); #1;
        push('0, 1'b0, 32'd0);
        @(posedge clk); #1;
        e = '0;
        push(e, 1'b1, 32'd0);

        // directed sequence
        run_instr(C_ADDU, 1'b0, -1);
        run_instr(C_LW,   1'b0, -1);
        run_instr(C_SW,   1'b0, -1);
        run_instr(C_BEQ,  1'b1, -1);
        run_instr(C_BEQ,  1'b0, -1);
        run_instr(C_JAL,  1'b0, -1);
        run_instr(C_JR,   1'b0, -1);
        run_instr(C_LW,   1'b0, 3);   // reset during MEM
        run_instr(C_ADDU, 1'b0, -1);
        run_instr(C_J,    1'b0, -1);
        run_instr(C_BEQ,  1'b0, -1);
        run_instr(C_NOP,  1'b0, -1);  // its FETCH shows a count of 3 since the reset

        // randomized instruction stream with occasional mid-instruction reset
        for (int n = 0; n < 400; n++) begin
            cls = $urandom_range(C_JAL);
            rph = -1;
            if ($urandom_range(15) == 0) rph = $urandom_range(cpi(cls) - 1, 1);
            run_instr(cls, 1'($urandom), rph);
        end

        for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clk);
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d want=0", sb_q.size());
        end
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
